ov5640_cfg_sequencer: RTL and testbench
=======================================

// Module: ov5640_cfg_sequencer
// PURPOSE
//  Sequences all OV5640 register writes onto the single SCCB write master.
//  Two sources: the boot-time init table (ROM) and runtime HPS writes from the
//  h2f register block's FIFO (start/address/data, paced by ready).
//  Init traffic has priority. Each write is routed to camera 0, camera 1 or both.
//  Table entries can insert millisecond delays.
// PARAMETERS
//  INIT_LEN      256       number of entries in the init table
//  DELAY_ADDR    16'hFFFE  address marking a delay entry (data = delay in ms)
//  TICKS_PER_MS  50000     clk_sys cycles per ms (50 MHz)
//  TIMEOUT_CYC   2000000   max cycles to wait for sccb_done before abort
//  AUTO_INIT     1         1: run the init table automatically after reset
// PORTS
//  clk_sys        in   1   system clock
//  reset_n        in   1   asynchronous reset, active-low
//  init_req       in   1   pulse: (re)run the init table
//  cam_sel        in   2   bit0 = cam0, bit1 = cam1; 2'b00 is treated as 2'b11
//  hps_start      in   1   pulse: hps_address/hps_data valid (from h2f FIFO)
//  hps_address    in   16  OV5640 register address
//  hps_data       in   8   OV5640 register value
//  hps_ready      out  1   may pop the next HPS FIFO word (drives ready_ov5640)
//  sccb_start     out  1   1-cycle pulse: issue a write to the SCCB master
//  sccb_address   out  16  register address, held stable until sccb_done
//  sccb_data      out  8   register value, held stable until sccb_done
//  sccb_cam       out  2   one-hot target camera for this write
//  sccb_done      in   1   1-cycle pulse: SCCB write finished
//  init_busy      out  1   init table in progress
//  init_done      out  1   sticky: init table completed since last init start
//  err_timeout    out  1   sticky: a write timed out; cleared by init_req
//  hps_overflow   out  1   sticky: HPS word dropped (holding full); cleared by init_req
// BEHAVIOUR
//  - Reset: all outputs 0 except hps_ready (0 in reset, 1 first cycle after).
//    FSM -> IDLE. AUTO_INIT=1 enters INIT_FETCH one cycle after reset release.
//  - HPS holding: 2-entry FIFO of {addr,data}.
//    hps_ready = (count==0) & !hps_start, so only one word is in flight (the h2f
//    FIFO presents start one cycle after its read request).
//    hps_start while count==2: word dropped, hps_overflow <= 1.
//  - FSM states: IDLE, INIT_FETCH, INIT_ISSUE, INIT_WAIT, DELAY, HPS_ISSUE,
//    HPS_WAIT.
//    IDLE: init pending -> INIT_FETCH; else holding non-empty -> HPS_ISSUE.
//    INIT_FETCH: ROM read (1-cycle latency), idx < INIT_LEN.
//      Addr == DELAY_ADDR -> DELAY; else -> INIT_ISSUE.
//      idx == INIT_LEN -> IDLE; init_done <= 1, init_busy <= 0.
//    DELAY: counts data*TICKS_PER_MS cycles (data 0 = 1 cycle), then idx++ and
//      -> INIT_FETCH. No SCCB traffic during DELAY.
//    *_ISSUE: sccb_start pulse for the lowest pending camera of the target mask,
//      then -> *_WAIT.
//    *_WAIT: on sccb_done, clear that camera bit. Bits remain -> *_ISSUE;
//      else advance (idx++ -> INIT_FETCH, or pop holding -> IDLE).
//      Timeout counter reaching TIMEOUT_CYC: err_timeout <= 1, treat as done.
//  - Target mask latched at ISSUE entry from cam_sel; changes mid-write are ignored.
//  - Init has priority, but never preempts an HPS write in *_WAIT. HPS words
//    queue in holding during init; once holding is full, hps_ready stays 0.
//  - init_req while init_busy: ignored. In IDLE/HPS_*: pended, taken at next IDLE.
//    Starting init: idx <= 0, init_done <= 0, sticky errors cleared.
//  - sccb_done outside *_WAIT: ignored.
//  - Async reset mid-operation aborts everything; the holding FIFO is flushed.
// STRUCTURE
//  Package ov5640_cfg_pkg: state enum, cfg_word_t struct {addr[15:0], data[7:0]},
//  DELAY_ADDR.
//  Sub-module ov5640_init_rom (INIT_LEN x 24 bit, registered output, $readmemh).
//  Sequencer FSM, holding FIFO and counters stay in this module.
// TESTING
//  1 Reset, AUTO_INIT=1, ROM {3008:82, FFFE:05, 3103:03}, TICKS_PER_MS=10
//    -> 2 writes with >=50 idle cycles between, then init_done=1.
//  2 cam_sel=00, HPS write 4300:30 -> sccb_start twice, sccb_cam 01 then 10,
//    hps_ready=0 until the second done.
//  3 3 hps_start pulses (hps_ready ignored) during init -> 2 queued and issued
//    after init, hps_overflow=1.
//  4 sccb_done withheld, TIMEOUT_CYC=100 -> err_timeout=1 at cycle 100,
//    sequencer advances to the next entry.
//  5 init_req during HPS_WAIT -> HPS write completes first, then idx restarts at 0.
//  6 reset_n low mid-DELAY -> outputs 0 immediately; init restarts from entry 0.

Source files
------------

// File: rtl/ov5640_cfg_pkg.sv
// ov5640_cfg_pkg: shared types and constants for the OV5640 configuration sequencer
package ov5640_cfg_pkg;
  localparam logic [15:0] DELAY_ADDR = 16'hFFFE;
  typedef enum logic [2:0] {
    S_IDLE, S_INIT_FETCH, S_INIT_ISSUE, S_INIT_WAIT, S_DELAY, S_HPS_ISSUE, S_HPS_WAIT
  } state_t;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } cfg_word_t;
endpackage

// File: rtl/ov5640_cfg_sequencer_if.sv
// ov5640_cfg_sequencer_if: HPS holding-FIFO handshake and SCCB write-master bus
interface ov5640_cfg_sequencer_if;
  logic        hps_start;
  logic [15:0] hps_address;
  logic [7:0]  hps_data;
  logic        hps_ready;
  logic        sccb_start;
  logic [15:0] sccb_address;
  logic [7:0]  sccb_data;
  logic [1:0]  sccb_cam;
  logic        sccb_done;
  modport master (
    input  hps_start, hps_address, hps_data, sccb_done,
    output hps_ready, sccb_start, sccb_address, sccb_data, sccb_cam
  );
  modport slave (
    output hps_start, hps_address, hps_data, sccb_done,
    input  hps_ready, sccb_start, sccb_address, sccb_data, sccb_cam
  );
endinterface

// File: rtl/ov5640_cfg_sequencer_rom.sv
// ov5640_init_rom: init table ROM, entry i at INIT_TABLE[i*24 +: 24], registered read
module ov5640_init_rom import ov5640_cfg_pkg::*; #(
  parameter int INIT_LEN = 256,
  parameter int AW = 9,
  parameter logic [INIT_LEN*24-1:0] INIT_TABLE = '0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output cfg_word_t     word
);
  cfg_word_t word_q;
  always_ff @(posedge clk)
    word_q <= (int'(addr) < INIT_LEN) ? cfg_word_t'(INIT_TABLE[int'(addr)*24 +: 24]) : '0;
  assign word = word_q;
endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// ov5640_cfg_sequencer: serialises init-table and HPS register writes onto one SCCB master,
// fanning each write out to the selected cameras, with table-driven ms delays.
module ov5640_cfg_sequencer import ov5640_cfg_pkg::*; #(
  parameter int INIT_LEN = 256,
  parameter logic [15:0] DELAY_ADDR = ov5640_cfg_pkg::DELAY_ADDR,
  parameter int TICKS_PER_MS = 50000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter bit AUTO_INIT = 1'b1,
  parameter logic [INIT_LEN*24-1:0] INIT_TABLE = '0
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic                          init_req,
  input  logic [1:0]                    cam_sel,
  ov5640_cfg_sequencer_if.master        bus,
  output logic                          init_busy,
  output logic                          init_done,
  output logic                          err_timeout,
  output logic                          hps_overflow
);
  localparam int IW = $clog2(INIT_LEN + 1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  cfg_word_t cur_q, cur_d, rom_word;
  cfg_word_t fifo_q [2], fifo_d [2];
  logic [1:0] cnt_q, cnt_d, mask_q, mask_d, cam_bit, sel_mask, rest;
  logic [31:0] tmo_q, tmo_d, dly_q, dly_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d, pend_q, pend_d, rdy_q;
  logic pop, push, tmo_hit, issue;

  ov5640_init_rom #(.INIT_LEN(INIT_LEN), .AW(IW), .INIT_TABLE(INIT_TABLE)) u_rom (
    .clk(clk_sys), .addr(idx_d), .word(rom_word)
  );

  assign sel_mask = (cam_sel == 2'b00) ? 2'b11 : cam_sel;
  assign cam_bit  = mask_q[0] ? 2'b01 : 2'b10;
  assign rest     = mask_q & ~cam_bit;
  assign tmo_hit  = tmo_q == 32'(TIMEOUT_CYC - 1);
  assign push     = bus.hps_start && cnt_q != 2'd2;
  assign issue    = state_q == S_INIT_ISSUE || state_q == S_HPS_ISSUE;

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cur_d = cur_q;
    mask_d = mask_q;
    tmo_d = tmo_q;
    dly_d = dly_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    ovf_d = ovf_q;
    fifo_d = fifo_q;
    pend_d = pend_q | (init_req & ~busy_q);
    pop = 1'b0;
    case (state_q)
      S_IDLE:
        if (pend_q || init_req) begin
          state_d = S_INIT_FETCH;
          idx_d = '0;
          done_d = 1'b0;
          err_d = 1'b0;
          ovf_d = 1'b0;
          busy_d = 1'b1;
          pend_d = 1'b0;
        end else if (cnt_q != 2'd0) begin
          state_d = S_HPS_ISSUE;
          cur_d = fifo_q[0];
          mask_d = sel_mask;
        end
      S_INIT_FETCH:
        if (idx_q == IW'(INIT_LEN)) begin
          state_d = S_IDLE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (rom_word.addr == DELAY_ADDR) begin
          state_d = S_DELAY;
          dly_d = (rom_word.data == 8'd0) ? '0 : 32'(rom_word.data) * 32'(TICKS_PER_MS) - 32'd1;
        end else begin
          state_d = S_INIT_ISSUE;
          cur_d = rom_word;
          mask_d = sel_mask;
        end
      S_INIT_ISSUE, S_HPS_ISSUE: begin
        tmo_d = '0;
        state_d = (state_q == S_INIT_ISSUE) ? S_INIT_WAIT : S_HPS_WAIT;
      end
      S_INIT_WAIT, S_HPS_WAIT: begin
        tmo_d = tmo_q + 32'd1;
        if (bus.sccb_done || tmo_hit) begin
          err_d = err_q | ~bus.sccb_done;
          mask_d = rest;
          if (rest != 2'b00) state_d = (state_q == S_INIT_WAIT) ? S_INIT_ISSUE : S_HPS_ISSUE;
          else if (state_q == S_INIT_WAIT) begin
            state_d = S_INIT_FETCH;
            idx_d = idx_q + IW'(1);
          end else begin
            state_d = S_IDLE;
            pop = 1'b1;
          end
        end
      end
      S_DELAY:
        if (dly_q == '0) begin
          state_d = S_INIT_FETCH;
          idx_d = idx_q + IW'(1);
        end else dly_d = dly_q - 32'd1;
      default: state_d = S_IDLE;
    endcase
    if (pop) fifo_d[0] = fifo_q[1];
    // with a pop in the same cycle the surviving word has already moved to slot 0
    if (push) fifo_d[cnt_q[0] & ~pop] = {bus.hps_address, bus.hps_data};
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    if (bus.hps_start && cnt_q == 2'd2) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      cur_q <= '0;
      mask_q <= '0;
      tmo_q <= '0;
      dly_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      fifo_q <= '{default: '0};
      cnt_q <= '0;
      pend_q <= AUTO_INIT;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cur_q <= cur_d;
      mask_q <= mask_d;
      tmo_q <= tmo_d;
      dly_q <= dly_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
      fifo_q <= fifo_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      rdy_q <= 1'b1;
    end

  assign bus.hps_ready    = rdy_q && cnt_q == 2'd0 && !bus.hps_start;
  assign bus.sccb_start   = issue;
  assign bus.sccb_address = cur_q.addr;
  assign bus.sccb_data    = cur_q.data;
  assign bus.sccb_cam     = (issue || state_q == S_INIT_WAIT || state_q == S_HPS_WAIT) ? cam_bit : 2'b00;
  assign init_busy        = busy_q;
  assign init_done        = done_q;
  assign err_timeout      = err_q;
  assign hps_overflow     = ovf_q;
endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// tb_ov5640_cfg_sequencer: directed vectors for HPS writes plus init/delay/timeout/reset sequences
module tb_ov5640_cfg_sequencer;
  import ov5640_cfg_pkg::*;
  logic clk_sys = 1'b0, reset_n = 1'b0, init_req = 1'b0;
  logic [1:0] cam_sel = 2'b01;
  logic init_busy, init_done, err_timeout, hps_overflow;
  ov5640_cfg_sequencer_if bus ();

  ov5640_cfg_sequencer #(
    .INIT_LEN(3), .TICKS_PER_MS(10), .TIMEOUT_CYC(100), .AUTO_INIT(1'b1),
    .INIT_TABLE({24'h3103_03, 24'hFFFE_05, 24'h3008_82})
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .init_req(init_req), .cam_sel(cam_sel),
    .bus(bus.master), .init_busy(init_busy), .init_done(init_done),
    .err_timeout(err_timeout), .hps_overflow(hps_overflow)
  );

  always #5 clk_sys = ~clk_sys;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  logic [15:0] la[$];
  logic [7:0]  ld[$];
  logic [1:0]  lc[$];
  int          lt[$];
  bit withhold = 1'b0;
  int nvec = 0, nerr = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] a;
    logic [7:0]  d;
    int          n;
    logic [1:0]  c0, c1;
  } vec_t;
  vec_t vt[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_log();
    la.delete(); ld.delete(); lc.delete(); lt.delete();
  endtask

  // SCCB master model: logs each start and answers with done 3 cycles later
  initial begin
    int cd = 0;
    bus.sccb_done = 1'b0;
    forever begin
      @(negedge clk_sys);
      bus.sccb_done = 1'b0;
      if (!reset_n) cd = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.sccb_done = 1'b1;
      end
      if (bus.sccb_start) begin
        la.push_back(bus.sccb_address);
        ld.push_back(bus.sccb_data);
        lc.push_back(bus.sccb_cam);
        lt.push_back(cyc);
        if (!withhold) cd = 3;
      end
    end
  end

  task automatic wait_sig(input string nm, input int bound, input int which);
    int n = 0;
    while (n < bound && !((which == 0 && init_done) || (which == 1 && bus.hps_ready) ||
                          (which == 2 && init_busy) || (which == 3 && la.size() > 0) ||
                          (which == 4 && err_timeout))) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= bound) begin
      nvec++;
      nerr++;
      $display("FAIL %s: timed out after %0d cycles", nm, bound);
    end
  endtask

  task automatic pulse_init();
    @(negedge clk_sys) init_req = 1'b1;
    @(negedge clk_sys) init_req = 1'b0;
  endtask

  task automatic hps_pulse(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    bus.hps_start = 1'b1; bus.hps_address = a; bus.hps_data = d;
    @(negedge clk_sys) bus.hps_start = 1'b0;
  endtask

  initial begin
    int t0;
    vt[0] = '{2'b00, 16'h4300, 8'h30, 2, 2'b01, 2'b10};
    vt[1] = '{2'b01, 16'h1234, 8'h56, 1, 2'b01, 2'b00};
    vt[2] = '{2'b10, 16'hABCD, 8'hEF, 1, 2'b10, 2'b00};
    vt[3] = '{2'b11, 16'h5A5A, 8'hA5, 2, 2'b01, 2'b10};
    vt[4] = '{2'b01, 16'hFFFE, 8'h07, 1, 2'b01, 2'b00};
    bus.hps_start = 1'b0; bus.hps_address = '0; bus.hps_data = '0;

    // reset state
    #12;
    check("rst_sccb_start", bus.sccb_start, 0);
    check("rst_sccb_cam", bus.sccb_cam, 0);
    check("rst_sccb_addr", bus.sccb_address, 0);
    check("rst_hps_ready", bus.hps_ready, 0);
    check("rst_busy", init_busy, 0);
    check("rst_done", init_done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_ovf", hps_overflow, 0);
    @(negedge clk_sys) reset_n = 1'b1;
    @(negedge clk_sys);
    check("post_rst_ready", bus.hps_ready, 1);
    check("auto_init_busy", init_busy, 1);

    // auto init with a 5 ms delay entry
    wait_sig("t1_init", 300, 0);
    check("t1_count", la.size(), 2);
    if (la.size() == 2) begin
      check("t1_a0", la[0], 16'h3008); check("t1_d0", ld[0], 8'h82); check("t1_c0", lc[0], 2'b01);
      check("t1_a1", la[1], 16'h3103); check("t1_d1", ld[1], 8'h03);
      check("t1_gap_ge_50", (lt[1] - lt[0]) >= 50, 1);
    end
    check("t1_busy_low", init_busy, 0);

    // HPS write vectors
    for (int i = 0; i < 5; i++) begin
      cam_sel = vt[i].sel;
      clr_log();
      wait_sig("vec_ready_in", 100, 1);
      hps_pulse(vt[i].a, vt[i].d);
      wait_sig("vec_ready_back", 100, 1);
      check($sformatf("vec%0d_count", i), la.size(), vt[i].n);
      if (la.size() > 0) begin
        check($sformatf("vec%0d_addr", i), la[0], vt[i].a);
        check($sformatf("vec%0d_data", i), ld[0], vt[i].d);
        check($sformatf("vec%0d_cam0", i), lc[0], vt[i].c0);
      end
      if (la.size() > 1) begin
        check($sformatf("vec%0d_cam1", i), lc[1], vt[i].c1);
        check($sformatf("vec%0d_addr1", i), la[1], vt[i].a);
      end
    end

    // three HPS words during init: two held, one dropped
    cam_sel = 2'b01;
    clr_log();
    pulse_init();
    @(negedge clk_sys); bus.hps_start = 1'b1; bus.hps_address = 16'h1111; bus.hps_data = 8'h01;
    @(negedge clk_sys); bus.hps_address = 16'h2222; bus.hps_data = 8'h02;
    @(negedge clk_sys); bus.hps_address = 16'h3333; bus.hps_data = 8'h03;
    @(negedge clk_sys); bus.hps_start = 1'b0;
    check("t3_ready_full", bus.hps_ready, 0);
    wait_sig("t3_init", 300, 0);
    wait_sig("t3_drain", 100, 1);
    check("t3_count", la.size(), 4);
    if (la.size() == 4) begin
      check("t3_init_first", la[0], 16'h3008);
      check("t3_hps_a", la[2], 16'h1111);
      check("t3_hps_b", la[3], 16'h2222);
    end
    check("t3_ovf", hps_overflow, 1);

    // SCCB never answers: each write times out
    withhold = 1'b1;
    clr_log();
    pulse_init();
    check("t4_ovf_cleared", hps_overflow, 0);
    check("t4_err_clear", err_timeout, 0);
    wait_sig("t4_first_start", 50, 3);
    t0 = (la.size() > 0) ? lt[0] : cyc;
    wait_sig("t4_err", 300, 4);
    check("t4_tmo_cycle", (cyc - t0) >= 100 && (cyc - t0) <= 101, 1);
    wait_sig("t4_init", 400, 0);
    check("t4_count", la.size(), 2);
    if (la.size() == 2) check("t4_next_entry", la[1], 16'h3103);
    check("t4_err_sticky", err_timeout, 1);
    withhold = 1'b0;

    // init_req arriving while an HPS write waits for done
    clr_log();
    hps_pulse(16'h7777, 8'h11);
    wait_sig("t5_hps_start", 50, 3);
    pulse_init();
    check("t5_not_preempted", init_busy, 0);
    wait_sig("t5_busy", 50, 2);
    wait_sig("t5_init", 300, 0);
    check("t5_count", la.size(), 3);
    if (la.size() == 3) begin
      check("t5_hps_first", la[0], 16'h7777);
      check("t5_idx0", la[1], 16'h3008);
      check("t5_idx2", la[2], 16'h3103);
    end
    check("t5_err_cleared", err_timeout, 0);

    // async reset in the middle of a delay entry
    clr_log();
    pulse_init();
    wait_sig("t6_first", 50, 3);
    repeat (20) @(negedge clk_sys);
    check("t6_in_delay", la.size(), 1);
    check("t6_busy", init_busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_busy_rst", init_busy, 0);
    check("t6_done_rst", init_done, 0);
    check("t6_ready_rst", bus.hps_ready, 0);
    check("t6_cam_rst", bus.sccb_cam, 0);
    clr_log();
    @(negedge clk_sys) reset_n = 1'b1;
    wait_sig("t6_init", 300, 0);
    check("t6_count", la.size(), 2);
    if (la.size() > 0) check("t6_restart", la[0], 16'h3008);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
